// File: rtl/obi_burst_reader_pkg.sv
// Shared types and constants for the OBI burst reader.
// Default OBI bus structs, FSM state encoding and address helper.
package obi_burst_reader_pkg;

  localparam logic [3:0] BE_ALL = 4'hF;
  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } obi_req_default_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_default_t;

  function automatic logic [31:0] next_addr(
    input logic [31:0] a
  );
    return a + 32'(WORD_BYTES);
  endfunction

endpackage

// File: rtl/obi_burst_reader_if.sv
// OBI initiator/responder bundle.
// Master drives the request, slave drives the response.
interface obi_burst_reader_if
  import obi_burst_reader_pkg::*;
#(
  parameter type obi_req_t  = obi_req_default_t,
  parameter type obi_resp_t = obi_resp_default_t
) (
  input logic clk_i
);

  obi_req_t  req;
  obi_resp_t resp;

  modport master (
    input  clk_i,
    output req,
    input  resp
  );

  modport slave (
    input  clk_i,
    input  req,
    output resp
  );

endinterface

// File: rtl/obi_burst_reader_fifo.sv
// First-word-fall-through return-data buffer.
// Head reads as zero while empty so the stream output is clean.
module obi_rdata_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign count_o = cnt_q;
  assign do_push = push_i && !full;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

  always_comb begin
    wptr_d = wptr_q + AW'(do_push);
    rptr_d = rptr_q + AW'(do_pop);
    cnt_d  = cnt_q + (AW+1)'(do_push)
                   - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/obi_burst_reader.sv
// OBI burst reader: issues sequential word reads and streams
// the returned data out through a credit-limited FWFT buffer.
module obi_burst_reader
  import obi_burst_reader_pkg::*;
#(
  parameter type obi_req_t        = obi_req_default_t,
  parameter type obi_resp_t       = obi_resp_default_t,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [31:0]          src_addr_i,
  input  logic [CNT_WIDTH-1:0] num_words_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output obi_req_t             obi_req_o,
  input  obi_resp_t            obi_resp_i,
  output logic [31:0]          data_o,
  output logic                 data_valid_o,
  input  logic                 data_ready_i
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  state_e               state_q, state_d;
  logic [31:0]          addr_q, addr_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] iss_q, iss_d;
  logic [CNT_WIDTH-1:0] iss_nxt;
  logic [CW-1:0]        outst_q, outst_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic [CW-1:0]        fifo_cnt;
  logic                 fifo_empty;
  logic [CW:0]          credit;
  logic                 req;
  logic                 fire;
  logic                 push;
  logic                 pop;

  // Words in flight plus words buffered never exceed the buffer size,
  // so every response always has a free slot.
  assign credit  = {1'b0, outst_q} + {1'b0, fifo_cnt};
  assign req     = (state_q == RUN) && (iss_q < cnt_q)
                && (credit < (CW+1)'(FIFO_DEPTH));
  assign fire    = req && obi_resp_i.gnt;
  assign push    = obi_resp_i.rvalid && (state_q != IDLE);
  assign pop     = data_valid_o && data_ready_i;
  assign iss_nxt = iss_q + CNT_WIDTH'(1);

  assign busy_o       = (state_q != IDLE);
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign data_valid_o = !fifo_empty;

  always_comb begin
    obi_req_o      = '0;
    obi_req_o.req  = req;
    obi_req_o.addr = addr_q;
    obi_req_o.be   = BE_ALL;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    iss_d   = iss_q;
    outst_d = outst_q + CW'(fire) - CW'(push);
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (src_addr_i[1:0] != 2'b00) begin
            err_d = 1'b1;
          end else if (num_words_i == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d  = src_addr_i;
            cnt_d   = num_words_i;
            iss_d   = '0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (fire) begin
          addr_d = next_addr(addr_q);
          iss_d  = iss_nxt;
          if (iss_nxt == cnt_q) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (outst_q == '0 && fifo_empty) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      iss_q   <= '0;
      outst_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      iss_q   <= iss_d;
      outst_q <= outst_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  obi_rdata_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .wdata_i (obi_resp_i.rdata),
    .pop_i   (pop),
    .rdata_o (data_o),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

endmodule

// File: tb/tb_obi_burst_reader.sv
// Directed bench for obi_burst_reader with an in-order
// responder model and grant/stream monitors.
module tb_obi_burst_reader;
  import obi_burst_reader_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] src;
  logic [15:0] nw;
  logic        busy, done, err;
  logic [31:0] data;
  logic        dv, rdy;

  logic        gnt_en, hold, rv;
  logic [31:0] rd;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  obi_burst_reader_if obi (.clk_i(clk));

  assign obi.resp = obi_resp_default_t'{
    gnt: gnt_en, rvalid: rv, rdata: rd};

  obi_burst_reader dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .src_addr_i   (src),
    .num_words_i  (nw),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .obi_req_o    (obi.req),
    .obi_resp_i   (obi.resp),
    .data_o       (data),
    .data_valid_o (dv),
    .data_ready_i (rdy)
  );

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  logic [31:0] pend[$];
  logic [31:0] gnt_log[$];
  int          gnt_cyc[$];
  logic [31:0] out_log[$];
  int          out_cyc[$];
  int          done_cnt, err_cnt, cyc;

  initial begin
    rv = 1'b0;
    rd = '0;
    cyc = 0;
    done_cnt = 0;
    err_cnt = 0;
  end

  always @(posedge clk) begin
    if (obi.req.req && gnt_en) begin
      gnt_log.push_back(obi.req.addr);
      gnt_cyc.push_back(cyc);
      pend.push_back(word_of(obi.req.addr));
    end
    if (dv && rdy) begin
      out_log.push_back(data);
      out_cyc.push_back(cyc);
    end
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (!hold && pend.size() != 0) begin
      rv <= 1'b1;
      rd <= pend.pop_front();
    end else begin
      rv <= 1'b0;
      rd <= '0;
    end
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    gnt_log.delete();
    gnt_cyc.delete();
    out_log.delete();
    out_cyc.delete();
    done_cnt = 0;
    err_cnt = 0;
  endtask

  task automatic pulse_start(input logic [31:0] a, input int n);
    src = a;
    nw = 16'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int k = 0; k < budget && busy; k++) @(negedge clk);
    chk({name, " idle"}, 32'(busy), 32'h0);
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] addr;
    int          n;
    int          exp_err;
    int          exp_done;
    int          exp_gnts;
  } vec_t;

  vec_t vt[5];

  initial begin
    logic [31:0] ea;
    int          ng;

    vt[0] = '{32'h0000_0100, 4, 0, 1, 4};
    vt[1] = '{32'h0000_0102, 2, 1, 0, 0};
    vt[2] = '{32'h0000_0000, 0, 0, 1, 0};
    vt[3] = '{32'hFFFF_FFF8, 3, 0, 1, 3};
    vt[4] = '{32'h0000_0040, 1, 0, 1, 1};

    rst = 1'b1;
    start = 1'b0;
    src = '0;
    nw = '0;
    rdy = 1'b1;
    gnt_en = 1'b0;
    hold = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst req", 32'(obi.req.req), 32'h0);
    chk("rst addr", obi.req.addr, 32'h0);
    chk("rst busy", 32'(busy), 32'h0);
    chk("rst done", 32'(done), 32'h0);
    chk("rst err", 32'(err), 32'h0);
    chk("rst dv", 32'(dv), 32'h0);
    chk("rst data", data, 32'h0);
    chk("rst we", 32'(obi.req.we), 32'h0);
    chk("rst be", 32'(obi.req.be), 32'hF);
    rst = 1'b0;
    gnt_en = 1'b1;
    @(negedge clk);
    chk("post rst busy", 32'(busy), 32'h0);

    // Consumer stalled: credit must cap grants at the buffer depth
    clear_logs();
    rdy = 1'b0;
    pulse_start(32'h0, 8);
    repeat (15) @(negedge clk);
    chk("stall gnts", 32'(gnt_log.size()), 32'd4);
    chk("stall req", 32'(obi.req.req), 32'h0);
    chk("stall busy", 32'(busy), 32'h1);
    chk("stall dv", 32'(dv), 32'h1);
    chk("stall head", data, word_of(32'h0));
    pulse_start(32'h800, 1);
    rdy = 1'b1;
    wait_idle("stall", 100);
    chk("stall gnts all", 32'(gnt_log.size()), 32'd8);
    chk("stall outs", 32'(out_log.size()), 32'd8);
    for (int j = 0; j < 8; j++) begin
      ea = 32'(4 * j);
      chk($sformatf("stall addr%0d", j),
          j < gnt_log.size() ? gnt_log[j] : 32'hDEAD_BEEF, ea);
      chk($sformatf("stall word%0d", j),
          j < out_log.size() ? out_log[j] : 32'hDEAD_BEEF,
          word_of(ea));
    end
    chk("stall done", 32'(done_cnt), 32'd1);
    chk("stall err", 32'(err_cnt), 32'd0);

    // Grant withheld: request must hold steady
    clear_logs();
    gnt_en = 1'b0;
    pulse_start(32'h300, 2);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("hold req%0d", k), 32'(obi.req.req), 32'h1);
      chk($sformatf("hold addr%0d", k), obi.req.addr, 32'h300);
      @(negedge clk);
    end
    gnt_en = 1'b1;
    wait_idle("hold", 50);
    chk("hold gnts", 32'(gnt_log.size()), 32'd2);
    chk("hold a0", gnt_log.size() > 0 ? gnt_log[0] : 32'hDEAD_BEEF,
        32'h300);
    chk("hold a1", gnt_log.size() > 1 ? gnt_log[1] : 32'hDEAD_BEEF,
        32'h304);
    chk("hold w1", out_log.size() > 1 ? out_log[1] : 32'hDEAD_BEEF,
        word_of(32'h304));
    chk("hold done", 32'(done_cnt), 32'd1);

    // Reset mid-burst with responses still in flight
    clear_logs();
    hold = 1'b1;
    pulse_start(32'h500, 8);
    for (int k = 0; k < 20 && gnt_log.size() < 2; k++)
      @(negedge clk);
    chk("mid gnts", 32'(gnt_log.size()), 32'd2);
    gnt_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid req", 32'(obi.req.req), 32'h0);
    chk("mid busy", 32'(busy), 32'h0);
    hold = 1'b0;
    gnt_en = 1'b1;
    repeat (8) @(negedge clk);
    chk("mid done", 32'(done_cnt), 32'd0);
    chk("mid outs", 32'(out_log.size()), 32'd0);
    chk("mid dv", 32'(dv), 32'h0);
    chk("mid gnts after", 32'(gnt_log.size()), 32'd2);

    // Single bursts with free-running responder and consumer
    for (int i = 0; i < 5; i++) begin
      clear_logs();
      rdy = 1'b1;
      gnt_en = 1'b1;
      pulse_start(vt[i].addr, vt[i].n);
      wait_idle($sformatf("v%0d", i), 50);
      ng = vt[i].exp_gnts;
      chk($sformatf("v%0d err", i), 32'(err_cnt), 32'(vt[i].exp_err));
      chk($sformatf("v%0d done", i), 32'(done_cnt),
          32'(vt[i].exp_done));
      chk($sformatf("v%0d gnts", i), 32'(gnt_log.size()), 32'(ng));
      chk($sformatf("v%0d outs", i), 32'(out_log.size()), 32'(ng));
      for (int j = 0; j < ng; j++) begin
        ea = vt[i].addr + 32'(4 * j);
        chk($sformatf("v%0d addr%0d", i, j),
            j < gnt_log.size() ? gnt_log[j] : 32'hDEAD_BEEF, ea);
        chk($sformatf("v%0d word%0d", i, j),
            j < out_log.size() ? out_log[j] : 32'hDEAD_BEEF,
            word_of(ea));
      end
      if (ng > 1) begin
        chk($sformatf("v%0d gnt span", i),
            gnt_log.size() == ng ? 32'(gnt_cyc[ng-1] - gnt_cyc[0])
                                 : 32'hFFFF,
            32'(ng - 1));
        chk($sformatf("v%0d out span", i),
            out_log.size() == ng ? 32'(out_cyc[ng-1] - out_cyc[0])
                                 : 32'hFFFF,
            32'(ng - 1));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/obi_burst_reader.md
OBI_BURST_READER -- requirements
Module: obi_burst_reader

Interface
REQ-001 SHALL have parameter obi_req_t, default logic, OBI request struct (req, we, addr, wdata, be).
REQ-002 SHALL have parameter obi_resp_t, default logic, OBI response struct (gnt, rvalid, rdata).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, return-data buffer depth in words (power of 2, >=2).
REQ-004 SHALL have parameter CNT_WIDTH, default 16, word-count width.
REQ-005 SHALL have one clock and a synchronous, active-high reset: clk_i  in  1  clock, all logic on rising edge.
REQ-006 rst_i  in  1  synchronous active-high reset.
REQ-007 start_i  in  1  start pulse, sampled only in IDLE.
REQ-008 src_addr_i  in  32  start byte address, must be word-aligned.
REQ-009 num_words_i  in  CNT_WIDTH  words to read.
REQ-010 busy_o  out  1  high while not IDLE.
REQ-011 done_o  out  1  one-cycle pulse on completion.
REQ-012 err_o  out  1  one-cycle pulse on rejected start.
REQ-013 obi_req_o  out  obi_req_t  OBI initiator request.
REQ-014 obi_resp_i  in  obi_resp_t  OBI responder response.
REQ-015 data_o  out  32  stream data; data_valid_o  out  1; data_ready_i  in  1 (valid/ready).

Function
REQ-016 SHALL implement FSM IDLE -> RUN -> DRAIN -> IDLE.
REQ-017 IDLE: start_i with src_addr_i[1:0]==0 and num_words_i!=0 latches address and count and enters RUN next cycle.
REQ-018 IDLE: start_i with src_addr_i[1:0]!=0 pulses err_o next cycle and stays IDLE.
REQ-019 IDLE: start_i with num_words_i==0 pulses done_o next cycle and issues no request.
REQ-020 start_i outside IDLE SHALL be ignored.
REQ-021 obi_req_o.we=0, be=4'hF, wdata=0 at all times.
REQ-022 RUN: req=1 when issued<count and (outstanding+fifo_count)<FIFO_DEPTH.
REQ-023 Once req=1, req and addr SHALL remain stable until the cycle gnt=1.
REQ-024 Each req&&gnt cycle: addr+=4 (32-bit wrap 0xFFFFFFFC->0), issued++, outstanding++.
REQ-025 Issue rate SHALL be up to one request per cycle; req may stay high back-to-back.
REQ-026 Each rvalid pushes rdata into FIFO and decrements outstanding; responses are in order with arbitrary latency >=1.
REQ-027 Credit rule (REQ-022) guarantees no push into a full FIFO; simultaneous gnt and rvalid SHALL leave outstanding unchanged.
REQ-028 FIFO is first-word-fall-through: data_valid_o=!empty, data_o=head, pop on data_valid_o&&data_ready_i; simultaneous push/pop SHALL keep count.
REQ-029 Pushed word SHALL become visible on data_o the cycle after rvalid.
REQ-030 RUN -> DRAIN when issued reaches count (the cycle of the last gnt).
REQ-031 DRAIN -> IDLE when outstanding==0 and FIFO empty; done_o pulses in the IDLE-entry cycle.
REQ-032 With 1-cycle responder latency and data_ready_i=1, throughput SHALL be one word per cycle.
REQ-033 rvalid received in IDLE SHALL be discarded.

Reset
REQ-034 rst_i SHALL return FSM to IDLE and clear counters, FIFO pointers, address.
REQ-035 During and after reset: req=0, busy_o=0, done_o=0, err_o=0, data_valid_o=0, data_o=0, addr=0.
REQ-036 Reset mid-RUN/DRAIN SHALL drop req immediately the cycle after rst_i and produce no done_o.

Structure
REQ-037 Shared package obi_burst_reader_pkg SHALL hold the FSM state enum and constants (BE_ALL=4'hF, WORD_BYTES=4).
REQ-038 FIFO SHALL be sub-module obi_rdata_fifo (parameter DEPTH, WIDTH=32, synchronous active-high reset).

Verification
REQ-039 Addr 0x100, 4 words, 1-cycle responder, ready=1 -> addrs 0x100,0x104,0x108,0x10C on 4 consecutive gnt cycles; data out in order; done_o 1 pulse.
REQ-040 Addr 0x0, 8 words, ready=0 -> at most 4 grants; req low until pops; after ready=1 all 8 words in order.
REQ-041 Gnt withheld 3 cycles -> req and addr stable for all 3 cycles; single issue on gnt.
REQ-042 Addr 0x102 -> err_o pulse, no req; num_words=0 -> done_o pulse, no req.
REQ-043 Addr 0xFFFFFFF8, 3 words -> addrs 0xFFFFFFF8, 0xFFFFFFFC, 0x0.
REQ-044 rst_i during RUN after 2 grants -> req=0 next cycle, busy_o=0, no done_o, late rvalid discarded.
